syncgen: RTL

VGA timing generator for the 640x480@60 Hz display path. Runs on the 25 MHz pixel clock produced by the pixel-clock generator and produces the horizontal/vertical counters, sync pulses, display-enable and frame/line start strobes. These outputs are consumed by the pattern and character-display pixel stages and the VGA output pins. All outputs are registered and mutually consistent in every cycle.

---
 rtl/syncgen_if.sv | 14 +
 rtl/syncgen.sv | 77 +++++++
 2 files changed

// File: rtl/syncgen_if.sv
// VGA timing bundle: counters, sync pulses, display enable and start strobes.
// master drives the bundle; slave is the consuming pixel stage.
interface syncgen_if;
   logic [9:0] HCNT;
   logic [9:0] VCNT;
   logic       HSYNC;
   logic       VSYNC;
   logic       DISP;
   logic       LSTART;
   logic       FSTART;

   modport master (output HCNT, VCNT, HSYNC, VSYNC, DISP, LSTART, FSTART);
   modport slave  (input  HCNT, VCNT, HSYNC, VSYNC, DISP, LSTART, FSTART);
endinterface

// File: rtl/syncgen.sv
// VGA timing generator (640x480@60 at defaults) on the pixel clock.
// Every output is a register and is consistent with the counters in the same cycle.
module syncgen #(
   parameter int unsigned HPERIOD = 800,
   parameter int unsigned HFRONT  = 16,
   parameter int unsigned HWIDTH  = 96,
   parameter int unsigned HBACK   = 48,
   parameter int unsigned VPERIOD = 525,
   parameter int unsigned VFRONT  = 10,
   parameter int unsigned VWIDTH  = 2,
   parameter int unsigned VBACK   = 33,
   parameter int unsigned SYNCPOL = 0
) (
   input  logic      PCK,
   input  logic      RST,
   syncgen_if.master vga
);
   localparam logic [9:0] HLAST = 10'(HPERIOD - 1);
   localparam logic [9:0] HDISP = 10'(HPERIOD - HFRONT - HWIDTH - HBACK);
   localparam logic [9:0] HSBEG = 10'(HPERIOD - HWIDTH - HBACK);
   localparam logic [9:0] HSEND = 10'(HPERIOD - HBACK);
   localparam logic [9:0] VLAST = 10'(VPERIOD - 1);
   localparam logic [9:0] VDISP = 10'(VPERIOD - VFRONT - VWIDTH - VBACK);
   localparam logic [9:0] VSBEG = 10'(VPERIOD - VWIDTH - VBACK);
   localparam logic [9:0] VSEND = 10'(VPERIOD - VBACK);
   localparam logic       SYNC_IDLE = (SYNCPOL == 0);

   logic [9:0] r_hcnt;
   logic [9:0] r_vcnt;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_disp;
   logic       r_lstart;
   logic       r_fstart;

   logic       w_hwrap;
   logic [9:0] w_hnext;
   logic [9:0] w_vnext;

   always_comb begin
      w_hwrap = (r_hcnt == HLAST);
      w_hnext = w_hwrap ? '0 : r_hcnt + 10'd1;
      w_vnext = r_vcnt;
      if (w_hwrap) begin
         w_vnext = (r_vcnt == VLAST) ? '0 : r_vcnt + 10'd1;
      end
   end

   // Flags decode the next counter values so they land on the same edge as the counters.
   always_ff @(posedge PCK) begin
      if (RST) begin
         r_hcnt   <= HLAST;
         r_vcnt   <= VLAST;
         r_hsync  <= SYNC_IDLE;
         r_vsync  <= SYNC_IDLE;
         r_disp   <= 1'b0;
         r_lstart <= 1'b0;
         r_fstart <= 1'b0;
      end else begin
         r_hcnt   <= w_hnext;
         r_vcnt   <= w_vnext;
         r_hsync  <= ((w_hnext >= HSBEG) && (w_hnext < HSEND)) ? ~SYNC_IDLE : SYNC_IDLE;
         r_vsync  <= ((w_vnext >= VSBEG) && (w_vnext < VSEND)) ? ~SYNC_IDLE : SYNC_IDLE;
         r_disp   <= (w_hnext < HDISP) && (w_vnext < VDISP);
         r_lstart <= (w_hnext == '0);
         r_fstart <= (w_hnext == '0) && (w_vnext == '0);
      end
   end

   assign vga.HCNT   = r_hcnt;
   assign vga.VCNT   = r_vcnt;
   assign vga.HSYNC  = r_hsync;
   assign vga.VSYNC  = r_vsync;
   assign vga.DISP   = r_disp;
   assign vga.LSTART = r_lstart;
   assign vga.FSTART = r_fstart;
endmodule
